// File: rtl/setup_sequencer.sv
// Door-lock mode controller: owns the live configuration and runs the setup_on/setup_end session handshake.
// Optional idle-keypad abort of a setup session is enabled by defining SETUP_TIMEOUT_EN.
package setup_pkg;
    typedef struct packed {
        logic       status;
        logic [3:0] digit1;
        logic [3:0] digit2;
        logic [3:0] digit3;
        logic [3:0] digit4;
    } pin_t;

    typedef struct packed {
        logic       bip_status;
        logic [6:0] bip_time;
        logic [6:0] tranca_aut_time;
        pin_t       master_pin;
        pin_t       pin1;
        pin_t       pin2;
        pin_t       pin3;
        pin_t       pin4;
    } setupPac_t;
endpackage

module setup_sequencer
    import setup_pkg::*;
#(
    parameter int          DEF_BIP_TIME   = 10,
    parameter int          DEF_LOCK_TIME  = 10,
    parameter logic [15:0] DEF_MASTER_PIN = 16'h1234,
    parameter int          TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        setup_req,
    input  logic        key_valid,
    output logic        op_key_valid,
    output logic        setup_key_valid,
    output logic        setup_on,
    input  logic        setup_end,
    output logic        setup_rst,
    input  setupPac_t   data_setup_new,
    output setupPac_t   cfg,
    input  logic [23:0] op_bcd,
    input  logic        op_bcd_enable,
    input  logic [23:0] setup_bcd,
    input  logic        setup_bcd_enable,
    output logic [23:0] bcd_out,
    output logic        bcd_enable,
    output logic        in_setup,
    output logic        cfg_updated
);

    typedef enum logic [2:0] {
        OPERATING,
        ACTIVE,
        COMMIT,
        RELEASE,
        ABORT
    } state_t;

    localparam setupPac_t CFG_DEFAULT = '{
        bip_status:      1'b1,
        bip_time:        7'(DEF_BIP_TIME),
        tranca_aut_time: 7'(DEF_LOCK_TIME),
        master_pin:      '{status: 1'b1,
                           digit1: DEF_MASTER_PIN[15:12], digit2: DEF_MASTER_PIN[11:8],
                           digit3: DEF_MASTER_PIN[7:4],   digit4: DEF_MASTER_PIN[3:0]},
        pin1:            '{status: 1'b1, digit1: 4'h0, digit2: 4'h0, digit3: 4'h0, digit4: 4'h0},
        pin2:            '{status: 1'b0, digit1: 4'hF, digit2: 4'hF, digit3: 4'hF, digit4: 4'hF},
        pin3:            '{status: 1'b0, digit1: 4'hF, digit2: 4'hF, digit3: 4'hF, digit4: 4'hF},
        pin4:            '{status: 1'b0, digit1: 4'hF, digit2: 4'hF, digit3: 4'hF, digit4: 4'hF}
    };

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    function automatic logic [6:0] clamp_time(input logic [6:0] t);
        if (t < 7'd5)
            clamp_time = 7'd5;
        else if (t > 7'd60)
            clamp_time = 7'd60;
        else
            clamp_time = t;
    endfunction

    // A user PIN holding a non-decimal digit can never be typed, so it is disabled.
    function automatic pin_t check_pin(input pin_t p);
        check_pin = p;
        if (p.digit1 > 4'd9 || p.digit2 > 4'd9 || p.digit3 > 4'd9 || p.digit4 > 4'd9)
            check_pin.status = 1'b0;
    endfunction

    function automatic setupPac_t commit_cfg(input setupPac_t nw, input pin_t keep_master);
        commit_cfg                 = nw;
        commit_cfg.bip_time        = clamp_time(nw.bip_time);
        commit_cfg.tranca_aut_time = clamp_time(nw.tranca_aut_time);
        commit_cfg.master_pin      = keep_master;
        commit_cfg.pin1.status     = 1'b1;
        commit_cfg.pin2            = check_pin(nw.pin2);
        commit_cfg.pin3            = check_pin(nw.pin3);
        commit_cfg.pin4            = check_pin(nw.pin4);
    endfunction

    state_t state;
    logic   setup_end_q;

`ifdef SETUP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] idle_cnt;
`else
    assign setup_rst = 1'b0;
`endif

    assign op_key_valid    = key_valid && (state == OPERATING);
    assign setup_key_valid = key_valid && (state == ACTIVE);

    // Return to OPERATING keys off the registered setup_end, giving the setup block a full cycle of setup_on=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= OPERATING;
            setup_on    <= 1'b0;
            in_setup    <= 1'b0;
            cfg_updated <= 1'b0;
            cfg         <= CFG_DEFAULT;
            setup_end_q <= 1'b1;
`ifdef SETUP_TIMEOUT_EN
            setup_rst   <= 1'b0;
            idle_cnt    <= '0;
`endif
        end else begin
            setup_end_q <= setup_end;
            cfg_updated <= 1'b0;
`ifdef SETUP_TIMEOUT_EN
            setup_rst   <= 1'b0;
`endif
            case (state)
                OPERATING: begin
                    if (setup_req && setup_end) begin
                        state    <= ACTIVE;
                        setup_on <= 1'b1;
                        in_setup <= 1'b1;
`ifdef SETUP_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                    end
                end
                ACTIVE: begin
                    if (!setup_end) begin
                        state <= COMMIT;
                    end
`ifdef SETUP_TIMEOUT_EN
                    else if (idle_cnt == IDLE_LIMIT) begin
                        state     <= ABORT;
                        setup_on  <= 1'b0;
                        setup_rst <= 1'b1;
                    end else if (key_valid) begin
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
`endif
                end
                COMMIT: begin
                    cfg         <= commit_cfg(data_setup_new, cfg.master_pin);
                    cfg_updated <= 1'b1;
                    setup_on    <= 1'b0;
                    state       <= RELEASE;
                end
                RELEASE: begin
                    if (setup_end_q) begin
                        state    <= OPERATING;
                        in_setup <= 1'b0;
                    end
                end
                ABORT: begin
`ifdef SETUP_TIMEOUT_EN
                    if (setup_end_q && !setup_rst) begin
`else
                    if (setup_end_q) begin
`endif
                        state    <= OPERATING;
                        in_setup <= 1'b0;
                    end
                end
                default: begin
                    state    <= OPERATING;
                    setup_on <= 1'b0;
                    in_setup <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_out    <= 24'hFFFFFF;
            bcd_enable <= 1'b0;
        end else begin
            bcd_out    <= in_setup ? setup_bcd : op_bcd;
            bcd_enable <= in_setup ? setup_bcd_enable : op_bcd_enable;
        end
    end

endmodule

// File: tb/tb_setup_sequencer.sv
// Self-checking bench for setup_sequencer: commit clamping/validation, key and display routing, abort and reset.
// Commit results are queued when a session is driven and compared when cfg_updated pulses.
module tb_setup_sequencer;
    import setup_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        setup_req = 1'b0;
    logic        key_valid = 1'b0;
    logic        op_key_valid;
    logic        setup_key_valid;
    logic        setup_on;
    logic        setup_end = 1'b1;
    logic        setup_rst;
    setupPac_t   data_setup_new;
    setupPac_t   cfg;
    logic [23:0] op_bcd = 24'h424242;
    logic        op_bcd_enable = 1'b1;
    logic [23:0] setup_bcd = 24'h000000;
    logic        setup_bcd_enable = 1'b0;
    logic [23:0] bcd_out;
    logic        bcd_enable;
    logic        in_setup;
    logic        cfg_updated;

    int total = 0;
    int bad = 0;
    int commits = 0;
    setupPac_t exp_q[$];

    setup_sequencer #(
        .DEF_BIP_TIME(10),
        .DEF_LOCK_TIME(10),
        .DEF_MASTER_PIN(16'h1234),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .setup_req(setup_req),
        .key_valid(key_valid),
        .op_key_valid(op_key_valid),
        .setup_key_valid(setup_key_valid),
        .setup_on(setup_on),
        .setup_end(setup_end),
        .setup_rst(setup_rst),
        .data_setup_new(data_setup_new),
        .cfg(cfg),
        .op_bcd(op_bcd),
        .op_bcd_enable(op_bcd_enable),
        .setup_bcd(setup_bcd),
        .setup_bcd_enable(setup_bcd_enable),
        .bcd_out(bcd_out),
        .bcd_enable(bcd_enable),
        .in_setup(in_setup),
        .cfg_updated(cfg_updated)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic pin_t mkpin(input logic s, input logic [15:0] d);
        mkpin = '{status: s, digit1: d[15:12], digit2: d[11:8], digit3: d[7:4], digit4: d[3:0]};
    endfunction

    function automatic setupPac_t mkcfg(input logic bs, input logic [6:0] bt, input logic [6:0] tt,
                                        input pin_t m, input pin_t p1, input pin_t p2,
                                        input pin_t p3, input pin_t p4);
        mkcfg = '{bip_status: bs, bip_time: bt, tranca_aut_time: tt, master_pin: m,
                  pin1: p1, pin2: p2, pin3: p3, pin4: p4};
    endfunction

    // Scoreboard consumer: every cfg_updated pulse must match the next queued commit.
    always @(negedge clk) begin
        if (!rst && cfg_updated) begin
            commits++;
            if (exp_q.size() == 0)
                check("cfg_unexpected_commit", 128'(cfg_updated), 128'(1'b0));
            else
                check("cfg_commit", 128'(cfg), 128'(exp_q.pop_front()));
        end
    end

    task automatic session(input setupPac_t nc, input setupPac_t ec, input logic [23:0] sbcd);
        setup_end = 1'b1;
        setup_req = 1'b1;
        tick();
        setup_req = 1'b0;
        check("enter_setup_on", 128'(setup_on), 128'(1'b1));
        check("enter_in_setup", 128'(in_setup), 128'(1'b1));
        key_valid        = 1'b1;
        setup_bcd        = sbcd;
        setup_bcd_enable = 1'b1;
        #1;
        check("active_setup_key", 128'(setup_key_valid), 128'(1'b1));
        check("active_op_key", 128'(op_key_valid), 128'(1'b0));
        tick();
        check("active_bcd_out", 128'(bcd_out), 128'(sbcd));
        check("active_bcd_en", 128'(bcd_enable), 128'(1'b1));
        key_valid      = 1'b0;
        data_setup_new = nc;
        setup_end      = 1'b0;
        exp_q.push_back(ec);
        tick();
        check("commit_setup_on_hold", 128'(setup_on), 128'(1'b1));
        check("commit_no_early_pulse", 128'(cfg_updated), 128'(1'b0));
        key_valid = 1'b1;
        #1;
        check("commit_op_key", 128'(op_key_valid), 128'(1'b0));
        check("commit_setup_key", 128'(setup_key_valid), 128'(1'b0));
        tick();
        check("commit_pulse", 128'(cfg_updated), 128'(1'b1));
        check("commit_setup_on_drop", 128'(setup_on), 128'(1'b0));
        check("release_setup_key", 128'(setup_key_valid), 128'(1'b0));
        setup_end = 1'b1;
        key_valid = 1'b0;
        tick();
        check("release_pulse_single", 128'(cfg_updated), 128'(1'b0));
        check("release_in_setup", 128'(in_setup), 128'(1'b1));
        setup_req = 1'b1;
        tick();
        setup_req = 1'b0;
        check("release_exit", 128'(in_setup), 128'(1'b0));
        key_valid = 1'b1;
        #1;
        check("oper_op_key", 128'(op_key_valid), 128'(1'b1));
        tick();
        check("req_dropped", 128'(in_setup), 128'(1'b0));
        check("oper_bcd_out", 128'(bcd_out), 128'(op_bcd));
        key_valid        = 1'b0;
        setup_bcd_enable = 1'b0;
    endtask

    setupPac_t def_cfg, nc1, ec1, nc2, ec2, nc3, ec3;

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        def_cfg = mkcfg(1'b1, 7'd10, 7'd10, mkpin(1'b1, 16'h1234), mkpin(1'b1, 16'h0000),
                        mkpin(1'b0, 16'hFFFF), mkpin(1'b0, 16'hFFFF), mkpin(1'b0, 16'hFFFF));
        nc1 = mkcfg(1'b0, 7'd70, 7'd2, mkpin(1'b1, 16'h9999), mkpin(1'b0, 16'h1111),
                    mkpin(1'b1, 16'h4567), mkpin(1'b1, 16'h9999), mkpin(1'b0, 16'h0000));
        ec1 = mkcfg(1'b0, 7'd60, 7'd5, mkpin(1'b1, 16'h1234), mkpin(1'b1, 16'h1111),
                    mkpin(1'b1, 16'h4567), mkpin(1'b1, 16'h9999), mkpin(1'b0, 16'h0000));
        nc2 = mkcfg(1'b1, 7'd5, 7'd61, mkpin(1'b1, 16'h5678), mkpin(1'b1, 16'h2222),
                    mkpin(1'b1, 16'hF000), mkpin(1'b1, 16'h1A23), mkpin(1'b1, 16'h0009));
        ec2 = mkcfg(1'b1, 7'd5, 7'd60, mkpin(1'b1, 16'h1234), mkpin(1'b1, 16'h2222),
                    mkpin(1'b0, 16'hF000), mkpin(1'b0, 16'h1A23), mkpin(1'b1, 16'h0009));
        nc3 = mkcfg(1'b1, 7'd4, 7'd60, mkpin(1'b0, 16'h0000), mkpin(1'b0, 16'h9876),
                    mkpin(1'b0, 16'h1111), mkpin(1'b1, 16'h3333), mkpin(1'b1, 16'hA000));
        ec3 = mkcfg(1'b1, 7'd5, 7'd60, mkpin(1'b1, 16'h1234), mkpin(1'b1, 16'h9876),
                    mkpin(1'b0, 16'h1111), mkpin(1'b1, 16'h3333), mkpin(1'b0, 16'hA000));
        data_setup_new = '0;

        tick();
        tick();
        check("rst_cfg", 128'(cfg), 128'(def_cfg));
        check("rst_bip_time", 128'(cfg.bip_time), 128'(7'd10));
        check("rst_lock_time", 128'(cfg.tranca_aut_time), 128'(7'd10));
        check("rst_master_pin", 128'(cfg.master_pin), 128'(17'h11234));
        check("rst_bcd_out", 128'(bcd_out), 128'(24'hFFFFFF));
        check("rst_bcd_en", 128'(bcd_enable), 128'(1'b0));
        check("rst_setup_on", 128'(setup_on), 128'(1'b0));
        check("rst_in_setup", 128'(in_setup), 128'(1'b0));
        check("rst_setup_rst", 128'(setup_rst), 128'(1'b0));
        rst = 1'b0;
        tick();
        check("oper_bcd_after_rst", 128'(bcd_out), 128'(op_bcd));

        session(nc1, ec1, 24'h123455);
        session(nc2, ec2, 24'h987654);
        session(nc3, ec3, 24'h000111);

`ifdef SETUP_TIMEOUT_EN
        begin
            int cyc;
            cyc = 0;
            setup_end = 1'b1;
            setup_req = 1'b1;
            tick();
            setup_req = 1'b0;
            for (int i = 1; i <= 40; i++) begin
                tick();
                if (setup_rst) begin
                    cyc = i;
                    break;
                end
            end
            check("timeout_cycles", 128'(cyc), 128'(16));
            check("abort_setup_on", 128'(setup_on), 128'(1'b0));
            tick();
            check("abort_rst_width", 128'(setup_rst), 128'(1'b0));
            for (int i = 0; i < 10 && in_setup; i++) tick();
            check("abort_return", 128'(in_setup), 128'(1'b0));
            check("abort_cfg_kept", 128'(cfg), 128'(ec3));
        end
`endif

        setup_end = 1'b0;
        setup_req = 1'b1;
        tick();
        setup_req = 1'b0;
        check("stale_setup_on", 128'(setup_on), 128'(1'b0));
        tick();
        check("stale_in_setup", 128'(in_setup), 128'(1'b0));
        setup_end = 1'b1;

        setup_req = 1'b1;
        tick();
        setup_req = 1'b0;
        check("pre_rst_setup_on", 128'(setup_on), 128'(1'b1));
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_setup_on", 128'(setup_on), 128'(1'b0));
        check("async_rst_in_setup", 128'(in_setup), 128'(1'b0));
        check("async_rst_cfg", 128'(cfg), 128'(def_cfg));
        check("async_rst_bcd", 128'(bcd_out), 128'(24'hFFFFFF));
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_setup_on", 128'(setup_on), 128'(1'b0));

        check("sb_drained", 128'(exp_q.size()), 128'(0));
        check("commit_count", 128'(commits), 128'(3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
